round_dec_iter: RTL and testbench

// - Iterative AES inverse-cipher engine. It is the decrypt counterpart of the combinational encrypt round.
// - Takes one 128-bit ciphertext block and runs the initial AddRoundKey, then NR inverse rounds, at one round per clock.
// - Round keys come from an external key store, addressed through key_idx and returned combinationally on round_key.
// - Sits between the block input handshake and the plaintext consumer. Encrypt and decrypt share the key store.

---
 rtl/round_dec_iter.sv | 166 ++++++++++++++++
 tb/tb_round_dec_iter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_dec_iter.sv
// Iterative AES inverse cipher: initial AddRoundKey, then NR inverse rounds at one per clock.
// Optional macro ROUND_DEC_OUT_HOLD_EN adds out_ready and holds vout/state_out until consumed.
module round_dec_iter #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic [127:0] state_out,
    output logic         vout,
`ifdef ROUND_DEC_OUT_HOLD_EN
    input  logic         out_ready,
`endif
    output logic         busy
);

    typedef enum logic {IDLE, ROUND} state_t;

    state_t       r_state, w_next;
    logic [127:0] r_st, r_out;
    logic [3:0]   r_cnt;
    logic         r_vout;
    logic         w_rdy, w_accept, w_last;
    logic [127:0] w_t, w_mix;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, aa;
        acc = '0;
        aa  = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p, acc;
        p   = x;
        acc = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [7:0]  x2, x4, x8;
        logic [31:0] res;
        res = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        for (int unsigned r = 0; r < 4; r++)
            res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        return res;
    endfunction

    // Byte (r,c) sits at [127-8*(4c+r)]; InvShiftRows takes row r from column c-r
    always_comb begin
        w_t = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                w_t[127-8*(4*c+r) -: 8] = inv_sbox(r_st[127-8*(4*((c+4-r)%4)+r) -: 8])
                                        ^ round_key[127-8*(4*c+r) -: 8];
            end
        end
    end

    always_comb begin
        w_mix = '0;
        for (int unsigned c = 0; c < 4; c++)
            w_mix[127-32*c -: 32] = inv_mix_col(w_t[127-32*c -: 32]);
    end

    always_comb begin
        w_next   = r_state;
        w_rdy    = 1'b0;
        w_accept = 1'b0;
        w_last   = 1'b0;
        busy     = 1'b0;
        key_idx  = 4'(NR);
        case (r_state)
            IDLE: begin
`ifdef ROUND_DEC_OUT_HOLD_EN
                w_rdy = !(r_vout && !out_ready);
`else
                w_rdy = 1'b1;
`endif
                w_accept = in_valid && w_rdy;
                if (w_accept) w_next = ROUND;
            end
            ROUND: begin
                busy    = 1'b1;
                key_idx = r_cnt;
                w_last  = (r_cnt == '0);
                if (w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_st    <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
            r_vout  <= 1'b0;
        end else begin
            r_state <= w_next;
`ifdef ROUND_DEC_OUT_HOLD_EN
            if (r_vout && out_ready) r_vout <= 1'b0;
`else
            r_vout <= 1'b0;
`endif
            if (w_accept) begin
                r_st  <= state_in ^ round_key;
                r_cnt <= 4'(NR - 1);
            end else if (r_state == ROUND) begin
                if (w_last) begin
                    r_out  <= w_t;
                    r_vout <= 1'b1;
                end else begin
                    r_st  <= w_mix;
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign in_ready  = w_rdy;
    assign state_out = r_out;
    assign vout      = r_vout;

endmodule

// File: tb/tb_round_dec_iter.sv
// Directed bench for round_dec_iter: FIPS-197 vectors at NR=10 and NR=14, back-to-back, reset abort.
// The external key store is emulated with a bench-side key expansion.
module tb_round_dec_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid10, in_ready10, vout10, busy10;
    logic [127:0] state_in10, round_key10, state_out10;
    logic [3:0]   key_idx10;
    logic         in_valid14, in_ready14, vout14, busy14;
    logic [127:0] state_in14, round_key14, state_out14;
    logic [3:0]   key_idx14;
`ifdef ROUND_DEC_OUT_HOLD_EN
    logic         out_ready10, out_ready14;
`endif

    logic [127:0] rk_tab [0:3][0:15];
    logic [1:0]   ksel10;
    int           n_cmp, n_bad;

    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    assign round_key10 = rk_tab[ksel10][key_idx10];
    assign round_key14 = rk_tab[2][key_idx14];

    round_dec_iter #(.NR(10)) dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10),
        .state_in(state_in10), .key_idx(key_idx10), .round_key(round_key10),
        .state_out(state_out10), .vout(vout10),
`ifdef ROUND_DEC_OUT_HOLD_EN
        .out_ready(out_ready10),
`endif
        .busy(busy10)
    );

    round_dec_iter #(.NR(14)) dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14),
        .state_in(state_in14), .key_idx(key_idx14), .round_key(round_key14),
        .state_out(state_out14), .vout(vout14),
`ifdef ROUND_DEC_OUT_HOLD_EN
        .out_ready(out_ready14),
`endif
        .busy(busy14)
    );

    function automatic logic [7:0] tb_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = tb_xt(aa);
        end
        return acc;
    endfunction

    function automatic logic [7:0] tb_rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward S-box: inverse (x^254) followed by the affine map
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] p, v;
        p = x;
        v = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = tb_mul(p, p);
            v = tb_mul(v, p);
        end
        return v ^ tb_rotl(v, 1) ^ tb_rotl(v, 2) ^ tb_rotl(v, 3) ^ tb_rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] tb_subword(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr, input int dst);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = tb_subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = tb_xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = tb_subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) rk_tab[dst][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            n_cmp += 4;
            if (vout10 !== 1'b0) begin n_bad++; $display("FAIL reset_vout k=%0d: got %b want 0", k, vout10); end
            if (in_ready10 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready k=%0d: got %b want 1", k, in_ready10); end
            if (key_idx10 !== 4'd10) begin n_bad++; $display("FAIL reset_key_idx k=%0d: got %0d want 10", k, key_idx10); end
            if (state_out10 !== 128'h0) begin n_bad++; $display("FAIL reset_state_out k=%0d: got %h want 0", k, state_out10); end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_and_check10(input logic [127:0] ct, input logic [127:0] pt, input logic [1:0] ks, input string nm);
        ksel10     = ks;
        state_in10 = ct;
        in_valid10 = 1'b1;
        n_cmp += 2;
        if (key_idx10 !== 4'd10) begin n_bad++; $display("FAIL %s_idle_key_idx: got %0d want 10", nm, key_idx10); end
        if (in_ready10 !== 1'b1) begin n_bad++; $display("FAIL %s_idle_ready: got %b want 1", nm, in_ready10); end
        @(posedge clk); #1;
        in_valid10 = 1'b0;
        state_in10 = ~ct;
        for (int j = 0; j <= 10; j++) begin
            n_cmp += 4;
            if (j < 10) begin
                if (key_idx10 !== 4'(9 - j)) begin n_bad++; $display("FAIL %s_key_idx j=%0d: got %0d want %0d", nm, j, key_idx10, 9 - j); end
                if (vout10 !== 1'b0) begin n_bad++; $display("FAIL %s_vout_early j=%0d: got %b want 0", nm, j, vout10); end
                if (busy10 !== 1'b1) begin n_bad++; $display("FAIL %s_busy j=%0d: got %b want 1", nm, j, busy10); end
                if (in_ready10 !== 1'b0) begin n_bad++; $display("FAIL %s_ready_busy j=%0d: got %b want 0", nm, j, in_ready10); end
                @(posedge clk); #1;
            end else begin
                if (vout10 !== 1'b1) begin n_bad++; $display("FAIL %s_vout: got %b want 1", nm, vout10); end
                if (state_out10 !== pt) begin n_bad++; $display("FAIL %s_pt: got %h want %h", nm, state_out10, pt); end
                if (in_ready10 !== 1'b1) begin n_bad++; $display("FAIL %s_ready_done: got %b want 1", nm, in_ready10); end
                if (busy10 !== 1'b0) begin n_bad++; $display("FAIL %s_busy_done: got %b want 0", nm, busy10); end
            end
        end
        @(posedge clk); #1;
        n_cmp += 2;
        if (vout10 !== 1'b0) begin n_bad++; $display("FAIL %s_vout_pulse: got %b want 0", nm, vout10); end
        if (state_out10 !== pt) begin n_bad++; $display("FAIL %s_pt_hold: got %h want %h", nm, state_out10, pt); end
    endtask

    task automatic test_fips_b();
        send_and_check10(CT_B, PT_B, 2'd0, "fips_b");
    endtask

    task automatic test_fips_c1();
        send_and_check10(CT_C1, PT_C, 2'd1, "fips_c1");
    endtask

    task automatic test_fips_c3();
        state_in14 = CT_C3;
        in_valid14 = 1'b1;
        n_cmp++;
        if (key_idx14 !== 4'd14) begin n_bad++; $display("FAIL c3_idle_key_idx: got %0d want 14", key_idx14); end
        @(posedge clk); #1;
        in_valid14 = 1'b0;
        state_in14 = '0;
        for (int j = 0; j <= 14; j++) begin
            n_cmp += 2;
            if (j < 14) begin
                if (key_idx14 !== 4'(13 - j)) begin n_bad++; $display("FAIL c3_key_idx j=%0d: got %0d want %0d", j, key_idx14, 13 - j); end
                if (vout14 !== 1'b0) begin n_bad++; $display("FAIL c3_vout_early j=%0d: got %b want 0", j, vout14); end
                @(posedge clk); #1;
            end else begin
                if (vout14 !== 1'b1) begin n_bad++; $display("FAIL c3_vout: got %b want 1", vout14); end
                if (state_out14 !== PT_C) begin n_bad++; $display("FAIL c3_pt: got %h want %h", state_out14, PT_C); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic       exp_done;
        logic [3:0] exp_idx;
        ksel10     = 2'd0;
        state_in10 = CT_B;
        in_valid10 = 1'b1;
        @(posedge clk); #1;
        state_in10 = CT_C1;
        for (int j = 0; j <= 21; j++) begin
            exp_done = (j == 10) || (j == 21);
            exp_idx  = (j <= 9) ? 4'(9 - j) : (j <= 20 && j != 10) ? 4'(20 - j) : 4'd10;
            n_cmp += 3;
            if (vout10 !== exp_done) begin n_bad++; $display("FAIL b2b_vout j=%0d: got %b want %b", j, vout10, exp_done); end
            if (in_ready10 !== exp_done) begin n_bad++; $display("FAIL b2b_ready j=%0d: got %b want %b", j, in_ready10, exp_done); end
            if (key_idx10 !== exp_idx) begin n_bad++; $display("FAIL b2b_key_idx j=%0d: got %0d want %0d", j, key_idx10, exp_idx); end
            if (j == 10) begin
                n_cmp++;
                if (state_out10 !== PT_B) begin n_bad++; $display("FAIL b2b_pt1: got %h want %h", state_out10, PT_B); end
                ksel10 = 2'd1;
            end
            if (j == 21) begin
                n_cmp++;
                if (state_out10 !== PT_C) begin n_bad++; $display("FAIL b2b_pt2: got %h want %h", state_out10, PT_C); end
                in_valid10 = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort();
        ksel10     = 2'd1;
        state_in10 = CT_C1;
        in_valid10 = 1'b1;
        @(posedge clk); #1;
        in_valid10 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp += 5;
        if (vout10 !== 1'b0) begin n_bad++; $display("FAIL abort_vout: got %b want 0", vout10); end
        if (in_ready10 !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", in_ready10); end
        if (busy10 !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy10); end
        if (key_idx10 !== 4'd10) begin n_bad++; $display("FAIL abort_key_idx: got %0d want 10", key_idx10); end
        if (state_out10 !== 128'h0) begin n_bad++; $display("FAIL abort_state_out: got %h want 0", state_out10); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (vout10 !== 1'b0) begin n_bad++; $display("FAIL abort_no_vout k=%0d: got %b want 0", k, vout10); end
            @(posedge clk); #1;
        end
        send_and_check10(CT_C1, PT_C, 2'd1, "abort_resend");
    endtask

`ifdef ROUND_DEC_OUT_HOLD_EN
    task automatic test_out_hold();
        ksel10      = 2'd1;
        state_in10  = CT_C1;
        in_valid10  = 1'b1;
        @(posedge clk); #1;
        in_valid10  = 1'b0;
        out_ready10 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        state_in10 = CT_B;
        in_valid10 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_cmp += 4;
            if (vout10 !== 1'b1) begin n_bad++; $display("FAIL hold_vout k=%0d: got %b want 1", k, vout10); end
            if (state_out10 !== PT_C) begin n_bad++; $display("FAIL hold_pt k=%0d: got %h want %h", k, state_out10, PT_C); end
            if (in_ready10 !== 1'b0) begin n_bad++; $display("FAIL hold_ready k=%0d: got %b want 0", k, in_ready10); end
            if (busy10 !== 1'b0) begin n_bad++; $display("FAIL hold_busy k=%0d: got %b want 0", k, busy10); end
            @(posedge clk); #1;
        end
        in_valid10  = 1'b0;
        out_ready10 = 1'b1;
        #1;
        n_cmp++;
        if (in_ready10 !== 1'b1) begin n_bad++; $display("FAIL hold_release_ready: got %b want 1", in_ready10); end
        @(posedge clk); #1;
        n_cmp += 2;
        if (vout10 !== 1'b0) begin n_bad++; $display("FAIL hold_consumed: got %b want 0", vout10); end
        if (state_out10 !== PT_C) begin n_bad++; $display("FAIL hold_pt_after: got %h want %h", state_out10, PT_C); end
    endtask
`endif

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        in_valid10 = 1'b0;
        in_valid14 = 1'b0;
        state_in10 = '0;
        state_in14 = '0;
        ksel10     = 2'd0;
`ifdef ROUND_DEC_OUT_HOLD_EN
        out_ready10 = 1'b1;
        out_ready14 = 1'b1;
`endif
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 16; r++) rk_tab[s][r] = '0;
        expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10, 0);
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10, 1);
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 2);

        test_reset();
        test_fips_b();
        test_fips_c1();
        test_fips_c3();
        test_back_to_back();
        test_reset_abort();
`ifdef ROUND_DEC_OUT_HOLD_EN
        test_out_hold();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
